fifo_wr_ctrl: RTL and testbench

Write-side pointer and status controller for the dual-clock FIFO. It runs entirely in the write clock domain. It takes the read pointer (Gray, already brought into this domain by the pointer synchronizer) and generates:
- the memory write address and enable;
- the write pointer in Gray code, which the read domain's synchronizer consumes;
- the full, almost-full and used-words status.

---
 rtl/fifo_wr_ctrl.sv | 86 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and status controller for a dual-clock FIFO.
// Runs entirely in the write clock domain. It produces the memory write
// strobe and address, and the Gray write pointer for the read-domain
// synchronizer. Full, almost-full and used-word status are computed against
// the synchronized Gray read pointer. Status is pessimistic because the read
// pointer arrives late, so a stale read pointer can only overstate fill.
module fifo_wr_ctrl #(
  parameter int AWIDTH      = 3,
  parameter int ALMOST_FULL = 6
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [AWIDTH:0]   rd_pntr_gray_i,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic [AWIDTH:0]   wr_pntr_gray_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   wrusedw_o
);

  localparam int PW = AWIDTH + 1;

  // Binary to reflected Gray code.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary as an XOR prefix running from the MSB downward.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_pattern;
  logic [PW-1:0] used_next;
  logic          full_next;
  logic          almost_full_next;

  // A write is taken only when requested, not full and not in reset.
  assign wr_en_o = wrreq_i & ~full_o & ~srst_i;

  // Compute the next pointer and all status from the next pointer and current read pointer.
  always_comb begin
    wbin_next        = wbin + PW'(wr_en_o);
    wgray_next       = bin2gray(wbin_next);
    rbin             = gray2bin(rd_pntr_gray_i);
    // Full means the write pointer is exactly one lap ahead of the read pointer.
    // In Gray code that is the read pointer with its two MSBs inverted.
    full_pattern     = {~rd_pntr_gray_i[AWIDTH:AWIDTH-1], rd_pntr_gray_i[AWIDTH-2:0]};
    full_next        = (wgray_next == full_pattern);
    used_next        = wbin_next - rbin;
    almost_full_next = (used_next >= PW'(ALMOST_FULL));
  end

  // Pointer and status registers. The Gray pointer leaves straight from this flop.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wbin          <= '0;
      wgray         <= '0;
      full_o        <= 1'b0;
      almost_full_o <= 1'b0;
      wrusedw_o     <= '0;
    end else begin
      wbin          <= wbin_next;
      wgray         <= wgray_next;
      full_o        <= full_next;
      almost_full_o <= almost_full_next;
      wrusedw_o     <= used_next;
    end
  end

  assign wr_addr_o      = wbin[AWIDTH-1:0];
  assign wr_pntr_gray_o = wgray;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl (AWIDTH=3, ALMOST_FULL=6). A count-based reference
// model tracks total words written and read as unbounded integers.
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       srst_i;
  logic       wrreq_i;
  logic [3:0] rd_pntr_gray_i;
  logic       wr_en_o;
  logic [2:0] wr_addr_o;
  logic [3:0] wr_pntr_gray_o;
  logic       full_o;
  logic       almost_full_o;
  logic [3:0] wrusedw_o;

  fifo_wr_ctrl #(.AWIDTH(3), .ALMOST_FULL(6)) dut (
    .clk_i          (clk),
    .srst_i         (srst_i),
    .wrreq_i        (wrreq_i),
    .rd_pntr_gray_i (rd_pntr_gray_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_pntr_gray_o (wr_pntr_gray_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .wrusedw_o      (wrusedw_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference state: total words written and read since the last reset.
  int wr_tot;
  int rd_tot;
  logic m_full;

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the strobe, clock, then check registered outputs.
  task automatic cycle(input bit wr, input int rd_target, input bit rst, input string tag);
    int used;
    bit acc;
    srst_i         = rst;
    wrreq_i        = wr;
    rd_pntr_gray_i = gray4(rd_target);
    acc            = wr && !m_full && !rst;
    #1;
    chk({tag, ".wr_en"}, 32'(wr_en_o), 32'(acc));
    @(posedge clk);
    if (rst) begin
      wr_tot = 0;
      rd_tot = 0;
      m_full = 1'b0;
      #1;
      chk({tag, ".rst_addr"}, 32'(wr_addr_o), 0);
      chk({tag, ".rst_gray"}, 32'(wr_pntr_gray_o), 0);
      chk({tag, ".rst_full"}, 32'(full_o), 0);
      chk({tag, ".rst_af"}, 32'(almost_full_o), 0);
      chk({tag, ".rst_used"}, 32'(wrusedw_o), 0);
    end else begin
      if (acc) wr_tot++;
      rd_tot = rd_target;
      used   = wr_tot - rd_tot;
      m_full = (used == 8);
      #1;
      chk({tag, ".addr"}, 32'(wr_addr_o), 32'(wr_tot % 8));
      chk({tag, ".gray"}, 32'(wr_pntr_gray_o), 32'(gray4(wr_tot)));
      chk({tag, ".full"}, 32'(full_o), 32'(used == 8));
      chk({tag, ".af"}, 32'(almost_full_o), 32'(used >= 6));
      chk({tag, ".used"}, 32'(wrusedw_o), 32'(used));
    end
    @(negedge clk);
  endtask

  logic [3:0] fill_gray [8];
  int hist [$];

  initial begin
    int rd_next;
    checks   = 0;
    failures = 0;
    wr_tot   = 0;
    rd_tot   = 0;
    m_full   = 1'b0;
    srst_i   = 1'b1;
    wrreq_i  = 1'b0;
    rd_pntr_gray_i = '0;
    fill_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    @(negedge clk);

    // Reset held two cycles with a write request pending.
    cycle(1, 0, 1, "reset0");
    cycle(1, 0, 1, "reset1");

    // Fill with the read pointer parked at zero.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, "fill");
      chk("fill.gray_seq", 32'(wr_pntr_gray_o), 32'(fill_gray[i]));
      chk("fill.af_lit", 32'(almost_full_o), 32'(i >= 5));
      chk("fill.full_lit", 32'(full_o), 32'(i == 7));
    end
    chk("fill.used8", 32'(wrusedw_o), 8);
    // Ninth request is dropped.
    cycle(1, 0, 0, "overflow");
    chk("overflow.wr_en", 32'(wr_en_o), 0);
    chk("overflow.used", 32'(wrusedw_o), 8);

    // Drain from full via the read pointer only.
    cycle(0, 1, 0, "drain1");
    chk("drain1.full", 32'(full_o), 0);
    chk("drain1.used", 32'(wrusedw_o), 7);
    cycle(0, 2, 0, "drain2");
    chk("drain2.af", 32'(almost_full_o), 1);
    chk("drain2.used", 32'(wrusedw_o), 6);
    cycle(0, 3, 0, "drain3");
    chk("drain3.af", 32'(almost_full_o), 0);
    chk("drain3.used", 32'(wrusedw_o), 5);

    // Simultaneous write and read advance keeps the count.
    cycle(1, 4, 0, "simul");
    chk("simul.used", 32'(wrusedw_o), 5);
    cycle(1, 4, 0, "refill");
    cycle(1, 4, 0, "refill");
    cycle(1, 4, 0, "refill");
    chk("refill.full", 32'(full_o), 1);
    // Read advances while full with a request: blocked this cycle, taken next.
    wrreq_i = 1'b1;
    rd_pntr_gray_i = gray4(5);
    #1;
    chk("fullrd.wr_en", 32'(wr_en_o), 0);
    cycle(1, 5, 0, "fullrd");
    chk("fullrd.full", 32'(full_o), 0);
    wrreq_i = 1'b1;
    #1;
    chk("fullrd.accept", 32'(wr_en_o), 1);
    cycle(1, 5, 0, "fullrd2");
    chk("fullrd2.full", 32'(full_o), 1);

    // Reset while full with a pending request.
    cycle(1, 5, 1, "rstfull");

    // Wrap: read pointer trails the write pointer by two cycles.
    hist.delete();
    hist.push_back(0);
    hist.push_back(0);
    for (int i = 0; i < 16; i++) begin
      cycle(1, hist[0], 0, "wrap");
      void'(hist.pop_front());
      hist.push_back(wr_tot);
      chk("wrap.full0", 32'(full_o), 0);
      if (i == 14) chk("wrap.gray15", 32'(wr_pntr_gray_o), 32'(4'b1000));
      if (i == 15) begin
        chk("wrap.gray0", 32'(wr_pntr_gray_o), 0);
        chk("wrap.addr0", 32'(wr_addr_o), 0);
      end
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        cycle($urandom_range(0, 1), 0, 1, "rand_rst");
      end else begin
        rd_next = rd_tot;
        if ($urandom_range(0, 2) == 0 && rd_next < wr_tot)
          rd_next = $urandom_range(rd_tot + 1, wr_tot);
        cycle($urandom_range(0, 3) != 0, rd_next, 0, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
